// File: rtl/cell_plotter.sv
// cell_plotter: takes cell updates (column, row, colour) from the Life engine
// through a valid/ready handshake, buffers them in a small FIFO and expands each
// one into a CELL_SIZE x CELL_SIZE pixel square on the VGA adapter's
// x/y/colour/plot interface, one pixel per clock. It also runs a full-screen
// black clear sweep on request.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   upd_valid/upd_ready     update handshake; upd_x/upd_y cell index, upd_colour
//   clear_req               one-cycle pulse requesting a full-screen clear
//   x, y, colour, plot      registered pixel write to the adapter
//   busy                    registered: drawing, clearing, queued work or pending clear
//
// Build option: define CELL_PLOTTER_GRID_LINES_EN to draw the right and bottom
// edge of every cell in blue (3'b001), in squares and in the clear sweep.
//
// state | meaning
// IDLE  | waiting; starts a pending clear first, otherwise pops the next update
// DRAW  | emitting the current square, dx fastest
// CLEAR | sweeping the whole screen, px fastest
module cell_plotter #(
  parameter int CELL_SIZE  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [7:0] upd_x,
  input  logic [7:0] upd_y,
  input  logic [2:0] upd_colour,
  input  logic       clear_req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int CS_LOG2 = $clog2(CELL_SIZE);
  localparam int DW      = (CS_LOG2 > 0) ? CS_LOG2 : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] D_LAST     = DW'(CELL_SIZE - 1);
  localparam logic [DW-1:0] D_ONE      = DW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]    CLR_X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0]    CLR_Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [10:0]   SCR_W11    = 11'(SCREEN_W);
  localparam logic [10:0]   SCR_H11    = 11'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] cx;
    logic [7:0] cy;
    logic [2:0] col;
  } entry_t;

  entry_t          fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;

  state_t          state_q;
  logic [7:0]      cell_x_q, cell_y_q;
  logic [2:0]      cell_col_q;
  logic [DW-1:0]   dx_q, dy_q;
  logic [7:0]      clr_x_q;
  logic [6:0]      clr_y_q;
  logic            clear_pending_q;

  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [2:0]      colour_q;
  logic            plot_q;
  logic            busy_q;

  logic            push, pop, flush;
  entry_t          head;
  logic [10:0]     px_draw, py_draw;
  logic            draw_vis;
  logic [2:0]      draw_colour, clear_colour;

  // Readiness looks only at the registered count, so a pop in the same cycle
  // does not open a slot early.
  assign upd_ready = (count_q != CNT_FULL) && (state_q != S_CLEAR);
  assign push      = upd_valid && upd_ready;
  assign pop       = (state_q == S_IDLE) && !clear_pending_q && (count_q != '0);
  assign flush     = (state_q == S_IDLE) && clear_pending_q;
  assign head      = fifo_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // 11-bit address so off-screen cells compare correctly before truncation.
  assign px_draw  = ({3'b000, cell_x_q} << CS_LOG2) + {{(11-DW){1'b0}}, dx_q};
  assign py_draw  = ({3'b000, cell_y_q} << CS_LOG2) + {{(11-DW){1'b0}}, dy_q};
  assign draw_vis = (px_draw < SCR_W11) && (py_draw < SCR_H11);

`ifdef CELL_PLOTTER_GRID_LINES_EN
  localparam logic [7:0] CX_MASK = 8'(CELL_SIZE - 1);
  localparam logic [6:0] CY_MASK = 7'(CELL_SIZE - 1);
  assign draw_colour  = ((dx_q == D_LAST) || (dy_q == D_LAST)) ? 3'b001 : cell_col_q;
  assign clear_colour = (((clr_x_q & CX_MASK) == CX_MASK) ||
                         ((clr_y_q & CY_MASK) == CY_MASK)) ? 3'b001 : 3'b000;
`else
  assign draw_colour  = cell_col_q;
  assign clear_colour = 3'b000;
`endif

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {upd_x, upd_y, upd_colour};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      state_q         <= S_IDLE;
      cell_x_q        <= '0;
      cell_y_q        <= '0;
      cell_col_q      <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      clr_x_q         <= '0;
      clr_y_q         <= '0;
      clear_pending_q <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      colour_q        <= '0;
      plot_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      busy_q  <= (state_q != S_IDLE) || (count_q != '0) || clear_pending_q;
      count_q <= count_d;
      plot_q  <= 1'b0;

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end

      case (state_q)
        S_IDLE: begin
          if (clear_pending_q) begin
            // A clear_req on this same edge is absorbed: the sweep starts at (0,0) anyway.
            clear_pending_q <= 1'b0;
            clr_x_q         <= '0;
            clr_y_q         <= '0;
            state_q         <= S_CLEAR;
          end else begin
            clear_pending_q <= clear_req;
            if (count_q != '0) begin
              cell_x_q   <= head.cx;
              cell_y_q   <= head.cy;
              cell_col_q <= head.col;
              dx_q       <= '0;
              dy_q       <= '0;
              state_q    <= S_DRAW;
            end
          end
        end

        S_DRAW: begin
          if (clear_req) begin
            // Abort the square; IDLE then starts the clear.
            clear_pending_q <= 1'b1;
            state_q         <= S_IDLE;
          end else begin
            x_q      <= px_draw[7:0];
            y_q      <= py_draw[6:0];
            colour_q <= draw_colour;
            plot_q   <= draw_vis;
            if (dx_q == D_LAST) begin
              dx_q <= '0;
              if (dy_q == D_LAST) begin
                state_q <= S_IDLE;
              end else begin
                dy_q <= dy_q + D_ONE;
              end
            end else begin
              dx_q <= dx_q + D_ONE;
            end
          end
        end

        S_CLEAR: begin
          x_q      <= clr_x_q;
          y_q      <= clr_y_q;
          colour_q <= clear_colour;
          plot_q   <= 1'b1;
          if (clear_req) begin
            clr_x_q <= '0;
            clr_y_q <= '0;
          end else if (clr_x_q == CLR_X_LAST) begin
            clr_x_q <= '0;
            if (clr_y_q == CLR_Y_LAST) begin
              state_q <= S_IDLE;
            end else begin
              clr_y_q <= clr_y_q + 7'd1;
            end
          end else begin
            clr_x_q <= clr_x_q + 8'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_cell_plotter.sv
module tb_cell_plotter;

  logic       clock = 1'b0;
  logic       reset;
  logic       upd_valid;
  logic       upd_ready;
  logic [7:0] upd_x;
  logic [7:0] upd_y;
  logic [2:0] upd_colour;
  logic       clear_req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  always #5 clock = ~clock;

  cell_plotter dut (
    .clock      (clock),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_x      (upd_x),
    .upd_y      (upd_y),
    .upd_colour (upd_colour),
    .clear_req  (clear_req),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy)
  );

`ifdef CELL_PLOTTER_GRID_LINES_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  typedef struct {
    int ux;
    int uy;
    int uc;
    int vis;
    int x0;
    int y0;
    int c0;
  } vec_t;

  pix_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   plot_cnt = 0;
  int   col1_cnt = 0;
  int   col7_cnt = 0;
  bit   first_seen = 1'b0;
  int   first_x, first_y, first_c;
  int   last_x, last_y;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // One clock; sample 1 ns after the edge and score any plotted pixel.
  task automatic tick();
    pix_t e;
    @(posedge clock);
    #1;
    if (plot === 1'b1) begin
      plot_cnt++;
      last_x = int'(x);
      last_y = int'(y);
      if (colour == 3'b001) col1_cnt++;
      if (colour == 3'b111) col7_cnt++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_x = int'(x);
        first_y = int'(y);
        first_c = int'(colour);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_plot: got (%0d,%0d,c%0d) want no plot", x, y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, colour} !== e) begin
          bad++;
          $display("FAIL pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                   x, y, colour, e.px, e.py, e.pc);
        end
      end
    end
  endtask

  function automatic logic [2:0] sq_colour(input int dx, input int dy, input int c);
    return (GRID && (dx == 3 || dy == 3)) ? 3'b001 : 3'(c);
  endfunction

  task automatic push_square(input int ux, input int uy, input int uc);
    pix_t p;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        int px = ux * 4 + dx;
        int py = uy * 4 + dy;
        if (px < 160 && py < 120) begin
          p.px = 8'(px);
          p.py = 7'(py);
          p.pc = sq_colour(dx, dy, uc);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic push_clear();
    pix_t p;
    for (int py = 0; py < 120; py++) begin
      for (int px = 0; px < 160; px++) begin
        p.px = 8'(px);
        p.py = 7'(py);
        p.pc = (GRID && ((px % 4) == 3 || (py % 4) == 3)) ? 3'b001 : 3'b000;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic send_upd(input int ux, input int uy, input int uc, output int rejected);
    bit acc;
    acc = 1'b0;
    rejected = 0;
    upd_x = 8'(ux);
    upd_y = 8'(uy);
    upd_colour = 3'(uc);
    upd_valid = 1'b1;
    while (!acc && rejected < 200) begin
      acc = upd_ready;
      tick();
      if (!acc) rejected++;
    end
    upd_valid = 1'b0;
    if (acc) push_square(ux, uy, uc);
    else fail_now("send_timeout");
  endtask

  task automatic wait_idle(input int budget);
    int n;
    tick();
    n = 1;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now("wait_idle_timeout");
  endtask

  vec_t vecs[8];
  int   rej;
  int   n;
  int   ready_bad;
  int   sweep_plots;
  int   busy_cycles;

  initial begin
    vecs[0] = '{ux: 2,   uy: 3,   uc: 7, vis: 16, x0: 8,   y0: 12,  c0: 7};
    vecs[1] = '{ux: 0,   uy: 0,   uc: 7, vis: 16, x0: 0,   y0: 0,   c0: 7};
    vecs[2] = '{ux: 39,  uy: 29,  uc: 0, vis: 16, x0: 156, y0: 116, c0: 0};
    vecs[3] = '{ux: 40,  uy: 30,  uc: 7, vis: 0,  x0: 0,   y0: 0,   c0: 0};
    vecs[4] = '{ux: 39,  uy: 30,  uc: 7, vis: 0,  x0: 0,   y0: 0,   c0: 0};
    vecs[5] = '{ux: 40,  uy: 0,   uc: 7, vis: 0,  x0: 0,   y0: 0,   c0: 0};
    vecs[6] = '{ux: 10,  uy: 5,   uc: 0, vis: 16, x0: 40,  y0: 20,  c0: 0};
    vecs[7] = '{ux: 255, uy: 255, uc: 7, vis: 0,  x0: 0,   y0: 0,   c0: 0};

    reset = 1'b1;
    upd_valid = 1'b0;
    upd_x = '0;
    upd_y = '0;
    upd_colour = '0;
    clear_req = 1'b0;
    repeat (3) tick();
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    reset = 1'b0;
    #1;
    check("rst_ready", int'(upd_ready), 1);

    // Single update: latency, raster run of 16, busy falling afterwards.
    plot_cnt = 0;
    first_seen = 1'b0;
    send_upd(2, 3, 7, rej);
    tick();
    check("t1_plot_k1", int'(plot), 0);
    tick();
    check("t1_plot_k2", int'(plot), 1);
    check("t1_busy_draw", int'(busy), 1);
    check("t1_first_x", first_x, 8);
    check("t1_first_y", first_y, 12);
    repeat (15) tick();
    check("t1_count", plot_cnt, 16);
    check("t1_last_x", last_x, 11);
    check("t1_last_y", last_y, 15);
    tick();
    check("t1_plot_end", int'(plot), 0);
    check("t1_busy_end", int'(busy), 0);
    check("t1_queue", exp_q.size(), 0);

    // Table of single updates, including clipped cells.
    for (int i = 0; i < 8; i++) begin
      plot_cnt = 0;
      first_seen = 1'b0;
      send_upd(vecs[i].ux, vecs[i].uy, vecs[i].uc, rej);
      wait_idle(200);
      check($sformatf("vec%0d_vis", i), plot_cnt, vecs[i].vis);
      if (vecs[i].vis > 0) begin
        check($sformatf("vec%0d_x0", i), first_x, vecs[i].x0);
        check($sformatf("vec%0d_y0", i), first_y, vecs[i].y0);
        check($sformatf("vec%0d_c0", i), first_c, vecs[i].c0);
      end
    end

    // Visible corner square followed by a fully clipped one.
    plot_cnt = 0;
    send_upd(39, 29, 0, rej);
    send_upd(40, 30, 7, rej);
    busy_cycles = 0;
    while (busy !== 1'b0 && busy_cycles < 34) begin
      tick();
      busy_cycles++;
    end
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
      busy_cycles++;
    end
    check("clip_busy_cycles", busy_cycles, 34);
    check("clip_plots", plot_cnt, 16);
    check("clip_last_x", last_x, 159);
    check("clip_last_y", last_y, 119);

    // FIFO fill while the first square is drawing.
    plot_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      send_upd(i, 2, (i % 2 == 0) ? 7 : 0, rej);
    end
    check("full_ready", int'(upd_ready), 0);
    send_upd(9, 2, 7, rej);
    check("full_wait", rej, 10);
    wait_idle(1000);
    check("full_plots", plot_cnt, 160);

    // Clear mid-square with queued work.
    plot_cnt = 0;
    send_upd(5, 5, 7, rej);
    send_upd(6, 5, 7, rej);
    send_upd(7, 5, 7, rej);
    send_upd(8, 5, 7, rej);
    n = 0;
    while (plot_cnt < 5 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail_now("clear_wait_draw");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_abort_plot", int'(plot), 0);
    exp_q.delete();
    push_clear();
    tick();
    check("clr_entry_plot", int'(plot), 0);
    check("clr_ready", int'(upd_ready), 0);
    upd_x = 8'd9;
    upd_y = 8'd9;
    upd_colour = 3'b111;
    upd_valid = 1'b1;
    ready_bad = 0;
    sweep_plots = 0;
    for (int i = 0; i < 19200; i++) begin
      tick();
      if (plot === 1'b1) sweep_plots++;
      if (i < 19199 && upd_ready !== 1'b0) ready_bad++;
    end
    upd_valid = 1'b0;
    check("clr_plots", sweep_plots, 19200);
    check("clr_ready_bad", ready_bad, 0);
    check("clr_last_x", last_x, 159);
    check("clr_last_y", last_y, 119);
    check("clr_queue", exp_q.size(), 0);
    tick();
    check("clr_done_plot", int'(plot), 0);
    wait_idle(100);

    // Reset in the middle of a clear.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    push_clear();
    repeat (100) tick();
    check("rstclr_plot_before", int'(plot), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rstclr_plot", int'(plot), 0);
    check("rstclr_busy", int'(busy), 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    plot_cnt = 0;
    first_seen = 1'b0;
    send_upd(1, 1, 7, rej);
    wait_idle(200);
    check("rstclr_redraw", plot_cnt, 16);
    check("rstclr_first_x", first_x, 4);

`ifdef CELL_PLOTTER_GRID_LINES_EN
    col1_cnt = 0;
    col7_cnt = 0;
    send_upd(0, 0, 7, rej);
    wait_idle(200);
    check("grid_blue", col1_cnt, 7);
    check("grid_white", col7_cnt, 9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
